// File: rtl/enc_top.sv
// SECDED (72,64) extended-Hamming encoder for the write path.
// One combinational encode stage feeding a single 72-bit output register.
module enc_top (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] IN,
    output logic [71:0] OUT
);

    // Builds the codeword: data into non-power-of-two slots, then check bits, then overall parity.
    function automatic logic [71:0] secded_encode(input logic [63:0] data);
        logic [71:0] cw;
        logic [6:0]  syn;
        logic [6:0]  pos;
        logic [5:0]  di;
        cw  = 72'h0;
        syn = 7'h0;
        di  = 6'd0;
        for (int p = 1; p < 72; p++) begin
            pos = 7'(p);
            if ((pos & (pos - 7'd1)) != 7'd0) begin
                cw[pos] = data[di];
                // Each set data bit toggles the check bits named by its position index.
                syn     = syn ^ ({7{data[di]}} & pos);
                di      = di + 6'd1;
            end else begin
                cw[pos] = 1'b0;
            end
        end
        cw[1]  = syn[0];
        cw[2]  = syn[1];
        cw[4]  = syn[2];
        cw[8]  = syn[3];
        cw[16] = syn[4];
        cw[32] = syn[5];
        cw[64] = syn[6];
        cw[0]  = even_parity71(cw[71:1]);
        return cw;
    endfunction

    // Overall parity bit that makes the full word even.
    function automatic logic even_parity71(input logic [70:0] bits);
        return ^bits;
    endfunction

    logic [71:0] code_s;
    logic [71:0] out_r;

    assign code_s = secded_encode(IN);

    // Output register; reset clears to the all-zero codeword.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= 72'h0;
        end else begin
            out_r <= code_s;
        end
    end

    assign OUT = out_r;

endmodule

// File: tb/tb_enc_top.sv
// Self-checking bench for enc_top: directed vector table, walking-one sweep,
// random stream with decoder checks, linearity and reset corner cases.
module tb_enc_top;

    logic        clk;
    logic        rst_n;
    logic [63:0] IN;
    logic [71:0] OUT;

    int n_checks;
    int n_fail;
    int pos_tab[64];

    enc_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .IN    (IN),
        .OUT   (OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] din;
        logic [71:0] expv;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference encoder: explicit position table, parity by scanning check groups.
    function automatic logic [71:0] model_enc(input logic [63:0] d);
        logic [71:0] cw;
        logic        par;
        cw = 72'h0;
        for (int j = 0; j < 64; j++) cw[pos_tab[j]] = d[j];
        for (int k = 0; k < 7; k++) begin
            par = 1'b0;
            for (int p = 1; p < 72; p++) if (p[k]) par = par ^ cw[p];
            cw[1 << k] = par;
        end
        cw[0] = ^cw[71:1];
        return cw;
    endfunction

    function automatic logic [6:0] syndrome(input logic [71:0] w);
        logic [6:0] s;
        s = 7'h0;
        for (int p = 1; p < 72; p++) if (w[p]) s = s ^ 7'(p);
        return s;
    endfunction

    initial begin
        int idx;
        logic [63:0] prev_in;
        logic [63:0] a;
        logic [63:0] b;
        logic [71:0] ea;
        logic [71:0] eb;
        logic [71:0] w;
        logic [71:0] f;
        logic [6:0]  pbits;
        int          b1;
        int          b2;

        n_checks = 0;
        n_fail   = 0;
        idx = 0;
        for (int p = 1; p < 72; p++) begin
            if ($countones(p) != 1) begin
                pos_tab[idx] = p;
                idx++;
            end
        end

        vecs[0] = '{64'h0,                   72'h0};
        vecs[1] = '{64'h1,                   72'h0F};
        vecs[2] = '{64'h2,                   72'h33};
        vecs[3] = '{64'h3,                   72'h3C};
        vecs[4] = '{64'h4,                   72'h55};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 72'hFF_FFFF_FFFF_FFFF_FFFF};
        vecs[6] = '{64'h8000_0000_0000_0000, 72'h81_0000_0000_0000_0017};
        vecs[7] = '{64'h0100_0000_0000_0000, 72'h00_8000_0001_0001_0117};

        // Reset held with all-ones input across clock edges.
        rst_n = 1'b0;
        IN    = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 chk("reset_async", OUT, 72'h0);
        repeat (3) begin
            @(posedge clk);
            #1 chk("reset_hold", OUT, 72'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("reset_release_hold", OUT, 72'h0);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            IN = vecs[i].din;
            @(posedge clk);
            #1 chk($sformatf("vec%0d", i), OUT, vecs[i].expv);
        end

        // Asynchronous reset mid-cycle, then clean restart.
        IN = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #2 chk("pre_async_rst", OUT, 72'hFF_FFFF_FFFF_FFFF_FFFF);
        rst_n = 1'b0;
        #1 chk("async_rst_clear", OUT, 72'h0);
        @(negedge clk);
        rst_n = 1'b1;
        IN = 64'h4;
        #1 chk("async_rst_hold", OUT, 72'h0);
        @(posedge clk);
        #1 chk("restart", OUT, 72'h55);

        // Walking one.
        for (int j = 0; j < 64; j++) begin
            IN = 64'h1 << j;
            @(posedge clk);
            #1;
            chk($sformatf("walk%0d_model", j), OUT, model_enc(64'h1 << j));
            chk($sformatf("walk%0d_databit", j), {71'h0, OUT[pos_tab[j]]}, 72'h1);
            pbits = {OUT[64], OUT[32], OUT[16], OUT[8], OUT[4], OUT[2], OUT[1]};
            chk($sformatf("walk%0d_parity", j), {65'h0, pbits}, 72'(pos_tab[j]));
            chk($sformatf("walk%0d_popcount_even", j), 72'($countones(OUT) % 2), 72'h0);
        end

        // Random back-to-back stream with decoder checks.
        prev_in = 64'h0;
        for (int n = 0; n < 10000; n++) begin
            a  = {$urandom, $urandom};
            IN = a;
            if (n > 0) begin
                w = OUT;
                chk("rand_model", w, model_enc(prev_in));
                chk("rand_clean", {64'h0, 1'b0, syndrome(w)} | 72'(^w), 72'h0);
                if (n < 100) begin
                    for (int bi = 0; bi < 72; bi++) begin
                        f = w ^ (72'h1 << bi);
                        chk("single_flip", {64'h0, ^f, syndrome(f)}, {64'h0, 1'b1, 7'(bi)});
                    end
                end
                b1 = $urandom_range(71, 0);
                b2 = (b1 + $urandom_range(71, 1)) % 72;
                f  = w ^ (72'h1 << b1) ^ (72'h1 << b2);
                chk("double_flip_parity", 72'(^f), 72'h0);
                chk("double_flip_syn_nz", 72'(syndrome(f) != 7'h0), 72'h1);
            end
            prev_in = a;
            @(posedge clk);
            #1;
        end
        chk("rand_last", OUT, model_enc(prev_in));

        // Linearity across consecutive cycles.
        for (int t = 0; t < 8; t++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            IN = a;
            @(posedge clk);
            #1 ea = OUT;
            IN = b;
            @(posedge clk);
            #1 eb = OUT;
            IN = a ^ b;
            @(posedge clk);
            #1;
            chk("linearity", OUT, ea ^ eb);
            chk("linearity_model", OUT, model_enc(a ^ b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/enc_top.md
Name: enc_top

Overview:
- SECDED (single-error-correct, double-error-detect) Hamming encoder, 64 data bits to a 72-bit codeword.
- Sits on the write path in front of the memory/link. Takes a 64-bit data word each clock and produces the extended-Hamming (72,64) codeword, registered.
- Pure datapath: no handshake; every clock edge encodes the current input.

Parameters:
- None. Widths are fixed at 64 data, 7 Hamming parity and 1 overall parity bit.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- IN  input  64  data word to encode.
- OUT  output  72  registered SECDED codeword.

Behaviour:
- Reset:
  - While rst_n=0, OUT is forced to 72'h0 immediately, independent of clk.
  - 72'h0 is the valid codeword for data 0.
  - On rst_n deassertion, OUT holds 0 until the next rising clk edge.
- Latency:
  - On every rising clk edge with rst_n=1, OUT <= encode(IN).
  - Exactly one cycle of latency; new input every cycle; no stall or enable.
- Codeword layout, Hamming positions 1..71 mapped to OUT[71:1]:
  - OUT[i] holds Hamming position i for i=1..71.
  - Parity bits sit at the power-of-two positions OUT[1], OUT[2], OUT[4], OUT[8], OUT[16], OUT[32], OUT[64].
  - Data bits fill the 64 non-power-of-two positions 3,5,6,7,9,...,63,65,...,71 in ascending order.
  - IN[0] goes to OUT[3], IN[1] to OUT[5], IN[2] to OUT[6], IN[3] to OUT[7], IN[4] to OUT[9], ..., IN[56] to OUT[63], IN[57] to OUT[65], ..., IN[63] to OUT[71].
- Hamming parity:
  - OUT[2^k] = XOR of all data positions p in 3..71 whose binary index has bit k set, for k=0..6.
  - This is even parity over each check group.
- Overall parity:
  - OUT[0] = XOR of OUT[71:1] after the Hamming parity bits are computed.
  - Result: the whole 72-bit word has even parity.
- Encoding is purely combinational ahead of a single 72-bit output register. No other state.
- Linearity:
  - encode(A XOR B) = encode(A) XOR encode(B).
  - The verification model may use this as a cross-check.
- No X propagation handling is required beyond standard RTL semantics.
- Reset mid-stream:
  - Asserting rst_n=0 at any point clears OUT asynchronously.
  - The pipeline restarts cleanly; the in-flight encode is discarded.

Test Plan:
- Reset: rst_n=0 with IN=64'hFFFF_FFFF_FFFF_FFFF, toggle clk -> OUT=72'h0 throughout. Assert rst_n asynchronously mid-cycle -> OUT clears without a clk edge.
- Sequential small values, one per cycle after reset release, IN = 0, 1, 2, 3, 4. Expect OUT one cycle later:
  - IN=0 -> 72'h0
  - IN=1 -> 72'h0F
  - IN=2 -> 72'h33
  - IN=3 -> 72'h3C
  - IN=4 -> 72'h55
- All-ones: IN=64'hFFFF_FFFF_FFFF_FFFF -> OUT=72'hFF_FFFF_FFFF_FFFF_FFFF (all seven Hamming parities = 1; overall parity = 1).
- Walking-one sweep, IN = 1<<j for j=0..63:
  - OUT has the data bit at its mapped position.
  - Parity bits equal the binary index of that position.
  - Total popcount of OUT is even.
  - Compare against a reference encoder model.
- Random stream: 10k random IN values back-to-back.
  - Each OUT equals the model encode of the IN from the previous cycle.
  - Decoder check: syndrome over OUT[71:1] is 0 and overall parity is 0.
  - Flipping any single bit gives a syndrome equal to that position (0 means OUT[0]) with overall parity 1.
  - Flipping any two bits gives a nonzero syndrome with overall parity 0.
- Linearity: for random A, B, encode(A^B) == encode(A)^encode(B), checked on consecutive cycles.
